hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 29 ++
 rtl/hazard_fw_cmp.sv | 34 +++
 rtl/hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants: forwarding-select encodings, hazard FSM states,
// the shadow-slot record and small helpers used by the hazard unit.
package hazard_ctrl_pkg;

  localparam logic [1:0] FW_RF  = 2'd0;
  localparam logic [1:0] FW_MEM = 2'd1;
  localparam logic [1:0] FW_WB  = 2'd2;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LDSTALL = 2'd1;
  localparam logic [1:0] ST_MWAIT   = 2'd2;

  typedef struct packed {
    logic [4:0] rd;
    logic       wb_en;
    logic       is_load;
  } shadow_t;

  // x0 is hard-wired zero, so it never produces a dependency
  function automatic logic reg_match(input logic [4:0] rs, input logic used,
                                     input logic [4:0] rd, input logic wb_en);
    return used && wb_en && (rs != 5'd0) && (rs == rd);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_fw_cmp.sv
// Per-source dependency comparator: picks the forwarding source for one
// operand and flags a load-use hazard against the EX slot.
module hazard_fw_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       used,
  input  logic [4:0] ex_rd,
  input  logic       ex_wb_en,
  input  logic       ex_is_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_wb_en,
  output logic [1:0] fw_sel,
  output logic       lu_hit
);

  logic ex_hit_s;
  logic mem_hit_s;

  // EX-slot match wins over MEM-slot match; a load in EX cannot forward yet
  always_comb begin
    ex_hit_s  = reg_match(rs, used, ex_rd, ex_wb_en);
    mem_hit_s = reg_match(rs, used, mem_rd, mem_wb_en);
    lu_hit    = ex_hit_s && ex_is_load;
    if (ex_hit_s && !ex_is_load) begin
      fw_sel = FW_MEM;
    end else if (mem_hit_s) begin
      fw_sel = FW_WB;
    end else begin
      fw_sel = FW_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: shadow destination tracking, operand forwarding
// selects, load-use stall, branch flush, memory-wait freeze and event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_rs1_used,
  input  logic        i_id_rs2_used,
  input  logic [4:0]  i_id_rd,
  input  logic        i_id_wb_en,
  input  logic        i_id_is_load,
  input  logic        i_ex_do_branch,
  input  logic        i_mem_req,
  input  logic        i_dmem_ready,
  output logic [1:0]  o_fw1_sel,
  output logic [1:0]  o_fw2_sel,
  output logic        o_stall,
  output logic        o_bubble,
  output logic        o_flush,
  output logic        o_freeze,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  shadow_t     ex_r;
  logic [4:0]  mem_rd_r;
  logic        mem_wb_en_r;
  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [1:0]  fw1_r;
  logic [1:0]  fw2_r;
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;
  logic [1:0]  fw1_nxt_s;
  logic [1:0]  fw2_nxt_s;
  logic        lu1_s;
  logic        lu2_s;
  logic        mem_wait_s;
  logic        freeze_s;
  logic        flush_s;
  logic        stall_s;

  hazard_fw_cmp u_cmp1 (
    .rs         (i_id_rs1),
    .used       (i_id_rs1_used),
    .ex_rd      (ex_r.rd),
    .ex_wb_en   (ex_r.wb_en),
    .ex_is_load (ex_r.is_load),
    .mem_rd     (mem_rd_r),
    .mem_wb_en  (mem_wb_en_r),
    .fw_sel     (fw1_nxt_s),
    .lu_hit     (lu1_s)
  );

  hazard_fw_cmp u_cmp2 (
    .rs         (i_id_rs2),
    .used       (i_id_rs2_used),
    .ex_rd      (ex_r.rd),
    .ex_wb_en   (ex_r.wb_en),
    .ex_is_load (ex_r.is_load),
    .mem_rd     (mem_rd_r),
    .mem_wb_en  (mem_wb_en_r),
    .fw_sel     (fw2_nxt_s),
    .lu_hit     (lu2_s)
  );

  // Control priority: freeze masks flush, flush squashes a load-use stall.
  // In MWAIT the freeze drops in the very cycle the memory reports ready.
  always_comb begin
    mem_wait_s = i_mem_req && !i_dmem_ready;
    if (!rst) begin
      freeze_s = 1'b0;
    end else if (state_r == ST_MWAIT) begin
      freeze_s = !i_dmem_ready;
    end else begin
      freeze_s = mem_wait_s;
    end
    flush_s = rst && !freeze_s && i_ex_do_branch;
    stall_s = rst && !freeze_s && !flush_s && (lu1_s || lu2_s);
  end

  // FSM next-state
  always_comb begin
    state_nxt_s = ST_RUN;
    case (state_r)
      ST_RUN: begin
        if (mem_wait_s) begin
          state_nxt_s = ST_MWAIT;
        end else if (stall_s) begin
          state_nxt_s = ST_LDSTALL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LDSTALL: begin
        if (mem_wait_s) begin
          state_nxt_s = ST_MWAIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MWAIT: begin
        if (i_dmem_ready) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_MWAIT;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shadow pipeline and forwarding selects advance together with ID/EX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_r.rd      <= 5'd0;
      ex_r.wb_en   <= 1'b0;
      ex_r.is_load <= 1'b0;
      mem_rd_r     <= 5'd0;
      mem_wb_en_r  <= 1'b0;
      fw1_r        <= FW_RF;
      fw2_r        <= FW_RF;
    end else if (!freeze_s) begin
      mem_rd_r    <= ex_r.rd;
      mem_wb_en_r <= ex_r.wb_en;
      if (stall_s || flush_s) begin
        ex_r.rd      <= 5'd0;
        ex_r.wb_en   <= 1'b0;
        ex_r.is_load <= 1'b0;
        fw1_r        <= FW_RF;
        fw2_r        <= FW_RF;
      end else begin
        ex_r.rd      <= i_id_rd;
        ex_r.wb_en   <= i_id_wb_en;
        ex_r.is_load <= i_id_is_load;
        fw1_r        <= fw1_nxt_s;
        fw2_r        <= fw2_nxt_s;
      end
    end
  end

  // Saturating event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (stall_s || freeze_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (flush_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

  assign o_fw1_sel   = fw1_r;
  assign o_fw2_sel   = fw2_r;
  assign o_stall     = stall_s;
  assign o_bubble    = stall_s;
  assign o_flush     = flush_s;
  assign o_freeze    = freeze_s;
  assign o_stall_cnt = stall_cnt_r;
  assign o_flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each task drives one scenario and checks
// hand-computed forwarding, stall, flush, freeze and counter values.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  i_id_rs1;
  logic [4:0]  i_id_rs2;
  logic        i_id_rs1_used;
  logic        i_id_rs2_used;
  logic [4:0]  i_id_rd;
  logic        i_id_wb_en;
  logic        i_id_is_load;
  logic        i_ex_do_branch;
  logic        i_mem_req;
  logic        i_dmem_ready;
  logic [1:0]  o_fw1_sel;
  logic [1:0]  o_fw2_sel;
  logic        o_stall;
  logic        o_bubble;
  logic        o_flush;
  logic        o_freeze;
  logic [31:0] o_stall_cnt;
  logic [31:0] o_flush_cnt;

  int errors;
  int checks;

  hazard_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .i_id_rs1       (i_id_rs1),
    .i_id_rs2       (i_id_rs2),
    .i_id_rs1_used  (i_id_rs1_used),
    .i_id_rs2_used  (i_id_rs2_used),
    .i_id_rd        (i_id_rd),
    .i_id_wb_en     (i_id_wb_en),
    .i_id_is_load   (i_id_is_load),
    .i_ex_do_branch (i_ex_do_branch),
    .i_mem_req      (i_mem_req),
    .i_dmem_ready   (i_dmem_ready),
    .o_fw1_sel      (o_fw1_sel),
    .o_fw2_sel      (o_fw2_sel),
    .o_stall        (o_stall),
    .o_bubble       (o_bubble),
    .o_flush        (o_flush),
    .o_freeze       (o_freeze),
    .o_stall_cnt    (o_stall_cnt),
    .o_flush_cnt    (o_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic wb, input logic ld);
    i_id_rs1 = rs1; i_id_rs1_used = u1;
    i_id_rs2 = rs2; i_id_rs2_used = u2;
    i_id_rd = rd; i_id_wb_en = wb; i_id_is_load = ld;
  endtask

  task automatic nops(input int n);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic apply_reset;
    i_ex_do_branch = 1'b0; i_mem_req = 1'b0; i_dmem_ready = 1'b0;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    i_ex_do_branch = 1'b1; i_mem_req = 1'b1; i_dmem_ready = 1'b0;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    checks++; if (o_freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze: got %0d expected 0", o_freeze); end
    checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %0d expected 0", o_flush); end
    checks++; if ({o_stall, o_bubble} !== 2'b00) begin errors++; $display("FAIL rst_stall: got %b expected 00", {o_stall, o_bubble}); end
    checks++; if ({o_fw1_sel, o_fw2_sel} !== 4'd0) begin errors++; $display("FAIL rst_fw: got %b expected 0000", {o_fw1_sel, o_fw2_sel}); end
    checks++; if (o_stall_cnt !== 32'd0 || o_flush_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", o_stall_cnt, o_flush_cnt); end
    i_ex_do_branch = 1'b0; i_mem_req = 1'b0;
    #10;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    nops(3);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);      // add x5
    tick();
    set_id(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);      // sub x6,x5,x1
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %0d expected 0", o_stall); end
    tick();
    checks++; if (o_fw1_sel !== 2'd1) begin errors++; $display("FAIL b2b_fw1_ex: got %0d expected 1", o_fw1_sel); end
    checks++; if (o_fw2_sel !== 2'd0) begin errors++; $display("FAIL b2b_fw2_ex: got %0d expected 0", o_fw2_sel); end
    nops(3);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);      // add x5
    tick();
    set_id(5'd2, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);      // independent
    tick();
    set_id(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);      // sub x6,x5,x1
    tick();
    checks++; if (o_fw1_sel !== 2'd2) begin errors++; $display("FAIL b2b_fw1_mem: got %0d expected 2", o_fw1_sel); end
    nops(3);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);      // x5 twice: younger wins
    tick();
    tick();
    set_id(5'd1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    checks++; if (o_fw2_sel !== 2'd1) begin errors++; $display("FAIL b2b_priority: got %0d expected 1", o_fw2_sel); end
  endtask

  task automatic test_x0;
    nops(3);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);      // addi x0
    tick();
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %0d expected 0", o_stall); end
    tick();
    checks++; if ({o_fw1_sel, o_fw2_sel} !== 4'd0) begin errors++; $display("FAIL x0_fw: got %b expected 0000", {o_fw1_sel, o_fw2_sel}); end
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);      // lw x0
    tick();
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL x0_load_stall: got %0d expected 0", o_stall); end
    tick();
  endtask

  task automatic test_load_use;
    nops(3);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);      // lw x7
    tick();
    set_id(5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);      // add x8,x7,x7
    #1;
    checks++; if ({o_stall, o_bubble} !== 2'b11) begin errors++; $display("FAIL lu_stall1: got %b expected 11", {o_stall, o_bubble}); end
    tick();
    checks++; if (o_fw1_sel !== 2'd0) begin errors++; $display("FAIL lu_fw_bubble: got %0d expected 0", o_fw1_sel); end
    #1;
    checks++; if ({o_stall, o_bubble} !== 2'b00) begin errors++; $display("FAIL lu_stall2: got %b expected 00", {o_stall, o_bubble}); end
    tick();
    checks++; if ({o_fw1_sel, o_fw2_sel} !== 4'b1010) begin errors++; $display("FAIL lu_fw_after: got %b expected 1010", {o_fw1_sel, o_fw2_sel}); end
    checks++; if (o_stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", o_stall_cnt); end
  endtask

  task automatic test_branch;
    nops(3);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);      // lw x7
    tick();
    set_id(5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    i_ex_do_branch = 1'b1;
    #1;
    checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL br_flush: got %0d expected 1", o_flush); end
    checks++; if ({o_stall, o_bubble} !== 2'b00) begin errors++; $display("FAIL br_stall: got %b expected 00", {o_stall, o_bubble}); end
    tick();
    i_ex_do_branch = 1'b0;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL br_flush_once: got %0d expected 0", o_flush); end
    tick();
    checks++; if (o_flush_cnt !== 32'd1) begin errors++; $display("FAIL br_flush_cnt: got %0d expected 1", o_flush_cnt); end
    checks++; if (o_stall_cnt !== 32'd1) begin errors++; $display("FAIL br_stall_cnt: got %0d expected 1", o_stall_cnt); end
  endtask

  task automatic test_mem_wait;
    apply_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);      // add x5
    tick();
    set_id(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);      // fw1 becomes 1
    tick();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    i_mem_req = 1'b1; i_dmem_ready = 1'b0; i_ex_do_branch = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({o_freeze, o_flush} !== 2'b10) begin errors++; $display("FAIL mw_freeze%0d: got %b expected 10", c, {o_freeze, o_flush}); end
      tick();
    end
    checks++; if (o_fw1_sel !== 2'd1) begin errors++; $display("FAIL mw_fw_hold: got %0d expected 1", o_fw1_sel); end
    i_dmem_ready = 1'b1;
    #1;
    checks++; if ({o_freeze, o_flush} !== 2'b01) begin errors++; $display("FAIL mw_release: got %b expected 01", {o_freeze, o_flush}); end
    tick();
    i_mem_req = 1'b0; i_ex_do_branch = 1'b0;
    #1;
    checks++; if (o_fw1_sel !== 2'd0) begin errors++; $display("FAIL mw_fw_flush: got %0d expected 0", o_fw1_sel); end
    checks++; if (o_stall_cnt !== 32'd3) begin errors++; $display("FAIL mw_stall_cnt: got %0d expected 3", o_stall_cnt); end
    checks++; if (o_flush_cnt !== 32'd1) begin errors++; $display("FAIL mw_flush_cnt: got %0d expected 1", o_flush_cnt); end
    tick();
  endtask

  task automatic test_reset_in_mwait;
    i_mem_req = 1'b1; i_dmem_ready = 1'b0;
    tick();
    #1;
    checks++; if (o_freeze !== 1'b1) begin errors++; $display("FAIL rm_freeze: got %0d expected 1", o_freeze); end
    rst = 1'b0;
    #1;
    checks++; if ({o_freeze, o_flush, o_stall, o_bubble} !== 4'd0) begin errors++; $display("FAIL rm_ctl: got %b expected 0000", {o_freeze, o_flush, o_stall, o_bubble}); end
    checks++; if (o_stall_cnt !== 32'd0 || o_flush_cnt !== 32'd0) begin errors++; $display("FAIL rm_cnt: got %0d/%0d expected 0/0", o_stall_cnt, o_flush_cnt); end
    i_mem_req = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    checks++; if (o_freeze !== 1'b0) begin errors++; $display("FAIL rm_after: got %0d expected 0", o_freeze); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_back_to_back();
    test_x0();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_reset_in_mwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
